// File: rtl/advanced_counter_core_pkg.sv
// Shared constants for the advanced counter slice.
// Default widths, prescaler width and direction encodings.
package advanced_counter_core_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_PRESCALE = 1;
   localparam int PS_W = 8;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/advanced_counter_core_if.sv
// Control/status bundle of the counting stage.
// master: upstream driver; slave: advanced_counter_core.
interface advanced_counter_core_if #(
   parameter int WIDTH = 8
);
   logic             inc_clk;
   logic             ref_clk;
   logic             enable;
   logic             dir;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] max_val;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] display_val;
   logic             overflow;
   logic             underflow;

   modport master (
      output inc_clk, ref_clk, enable, dir,
      output clear, load, load_val, max_val,
      input  count, display_val,
      input  overflow, underflow
   );

   modport slave (
      input  inc_clk, ref_clk, enable, dir,
      input  clear, load, load_val, max_val,
      output count, display_val,
      output overflow, underflow
   );
endinterface

// File: rtl/advanced_counter_core_pulse_prescaler.sv
// pulse_prescaler: emits tick on every PRESCALE-th enabled pulse.
// Ports: clk, reset (async, low), pulse, enable, sclr -> tick.
module pulse_prescaler
   import advanced_counter_core_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic pulse,
   input  logic enable,
   input  logic sclr,
   output logic tick
);

   localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] pcnt;
   logic            hit;

   assign hit  = pulse && enable;
   assign tick = hit && (pcnt == LAST);

   // enable low holds the partial count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcnt <= '0;
      end else if (sclr) begin
         pcnt <= '0;
      end else if (hit) begin
         pcnt <= tick ? '0 : pcnt + 1'b1;
      end
   end

endmodule

// File: rtl/advanced_counter_core.sv
// Up/down modulo counter with load, clear, prescaler, flags, display latch.
// Ports: clk, reset (async, low), bus (slave). Macro: COUNTER_SATURATE_EN.
module advanced_counter_core
   import advanced_counter_core_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic clk,
   input  logic reset,
   advanced_counter_core_if.slave bus
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] disp;
   logic [WIDTH-1:0] lim;
   logic             ovf;
   logic             unf;
   logic             tick;

   pulse_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_pre (
      .clk    (clk),
      .reset  (reset),
      .pulse  (bus.inc_clk),
      .enable (bus.enable),
      .sclr   (bus.clear | bus.load),
      .tick   (tick)
   );

   always_comb begin
      lim = bus.load_val;
      if (bus.load_val > bus.max_val)
         lim = bus.max_val;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         disp <= '0;
         ovf  <= 1'b0;
         unf  <= 1'b0;
      end else begin
         ovf <= 1'b0;
         unf <= 1'b0;
         // latch the value before this edge's update
         if (bus.ref_clk)
            disp <= cnt;
         if (bus.clear) begin
            cnt <= '0;
         end else if (bus.load) begin
            cnt <= lim;
         end else if (tick) begin
            if (bus.dir == DIR_UP) begin
               if (cnt >= bus.max_val) begin
`ifdef COUNTER_SATURATE_EN
                  cnt <= bus.max_val;
`else
                  cnt <= '0;
`endif
                  ovf <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end else begin
               if (cnt == '0) begin
`ifdef COUNTER_SATURATE_EN
                  cnt <= '0;
`else
                  cnt <= bus.max_val;
`endif
                  unf <= 1'b1;
               end else if (cnt > bus.max_val) begin
                  // limit lowered under us: snap down, silently
                  cnt <= bus.max_val;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
         end
      end
   end

   assign bus.count       = cnt;
   assign bus.display_val = disp;
   assign bus.overflow    = ovf;
   assign bus.underflow   = unf;

endmodule
